// File: rtl/d7s_scan_ctrl.sv
// rtl/d7s_scan_ctrl.sv - 3-digit multiplexed seven-segment scan scheduler
// Double-buffered BCD display value, inter-digit blanking and leading-zero suppression.
module d7s_scan_ctrl #(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter bit LZ_SUPPRESS  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load_valid,
  input  logic [11:0] load_bcd,
  output logic        load_ready,
  output logic [6:0]  seg,
  output logic [2:0]  digit_sel,
  output logic        frame_done
);

  localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);
  localparam int BLANK_LAST_I = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
  localparam int DWELL_LAST_I = DWELL_CYCLES - 1;
  localparam logic [CW-1:0] BLANK_LAST = BLANK_LAST_I[CW-1:0];
  localparam logic [CW-1:0] DWELL_LAST = DWELL_LAST_I[CW-1:0];

  typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_SHOW} state_t;

  state_t        state, state_n;
  logic [1:0]    idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [11:0]   display, display_n;
  logic [11:0]   pending;
  logic          pending_valid;
  logic          commit, accept, frame_done_n;
  logic [6:0]    seg_n;
  logic [2:0]    digit_sel_n;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'd0:    decode = 7'b1111110;
      4'd1:    decode = 7'b0110000;
      4'd2:    decode = 7'b1101101;
      4'd3:    decode = 7'b1111001;
      4'd4:    decode = 7'b0110011;
      4'd5:    decode = 7'b1011011;
      4'd6:    decode = 7'b1011111;
      4'd7:    decode = 7'b1110000;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1111011;
      default: decode = 7'b0000001;
    endcase
  endfunction

  // Suppressed digits still get their transistor enabled so brightness stays uniform.
  function automatic logic [6:0] digit_seg(input logic [1:0] i, input logic [11:0] v);
    logic [3:0] nib;
    logic       blank;
    case (i)
      2'd0:    nib = v[3:0];
      2'd1:    nib = v[7:4];
      default: nib = v[11:8];
    endcase
    blank = LZ_SUPPRESS && (((i == 2'd2) && (v[11:8] == 4'd0)) ||
                            ((i == 2'd1) && (v[11:4] == 8'd0)));
    digit_seg = blank ? 7'd0 : decode(nib);
  endfunction

  assign load_ready = ~pending_valid & ~rst;

  always_comb begin
    state_n      = state;
    idx_n        = idx;
    cnt_n        = cnt;
    commit       = 1'b0;
    frame_done_n = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) begin
          commit  = pending_valid;
          idx_n   = 2'd0;
          cnt_n   = '0;
          state_n = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
        end
      end
      ST_BLANK: begin
        if (!en) begin
          state_n = ST_IDLE;
          idx_n   = 2'd0;
          cnt_n   = '0;
        end else if (cnt == BLANK_LAST) begin
          state_n = ST_SHOW;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_SHOW: begin
        if (!en) begin
          state_n = ST_IDLE;
          idx_n   = 2'd0;
          cnt_n   = '0;
        end else if (cnt == DWELL_LAST) begin
          cnt_n   = '0;
          state_n = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
          if (idx == 2'd2) begin
            idx_n        = 2'd0;
            commit       = pending_valid;
            frame_done_n = 1'b1;
          end else begin
            idx_n = idx + 2'd1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        idx_n   = 2'd0;
        cnt_n   = '0;
      end
    endcase

    accept    = load_valid & load_ready;
    display_n = commit ? pending : display;
    // Outputs are computed from the next state so seg and digit_sel switch together.
    seg_n       = (state_n == ST_SHOW) ? digit_seg(idx_n, display_n) : 7'd0;
    digit_sel_n = (state_n == ST_SHOW) ? (3'b001 << idx_n) : 3'b000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      idx           <= 2'd0;
      cnt           <= '0;
      display       <= 12'h000;
      pending       <= 12'h000;
      pending_valid <= 1'b0;
      seg           <= 7'd0;
      digit_sel     <= 3'd0;
      frame_done    <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      display    <= display_n;
      seg        <= seg_n;
      digit_sel  <= digit_sel_n;
      frame_done <= frame_done_n;
      if (accept) begin
        pending <= load_bcd;
      end
      if (commit) begin
        pending_valid <= 1'b0;
      end else if (accept) begin
        pending_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_d7s_scan_ctrl.sv
// tb/tb_d7s_scan_ctrl.sv - directed bench for d7s_scan_ctrl
// Three instances: default blanking with LZ, blanking without LZ, and no blanking gap.
module tb_d7s_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load_valid;
  logic [11:0] load_bcd;

  logic        rdy_a, rdy_b, rdy_c;
  logic [6:0]  seg_a, seg_b, seg_c;
  logic [2:0]  sel_a, sel_b, sel_c;
  logic        fd_a, fd_b, fd_c;

  int          ds;
  logic        obs_rdy, obs_fd;
  logic [6:0]  obs_seg;
  logic [2:0]  obs_sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  d7s_scan_ctrl #(.DWELL_CYCLES(4), .BLANK_CYCLES(2), .LZ_SUPPRESS(1'b1)) u_main (
    .clk(clk), .rst(rst), .en(en), .load_valid(load_valid), .load_bcd(load_bcd),
    .load_ready(rdy_a), .seg(seg_a), .digit_sel(sel_a), .frame_done(fd_a)
  );

  d7s_scan_ctrl #(.DWELL_CYCLES(4), .BLANK_CYCLES(2), .LZ_SUPPRESS(1'b0)) u_nlz (
    .clk(clk), .rst(rst), .en(en), .load_valid(load_valid), .load_bcd(load_bcd),
    .load_ready(rdy_b), .seg(seg_b), .digit_sel(sel_b), .frame_done(fd_b)
  );

  d7s_scan_ctrl #(.DWELL_CYCLES(4), .BLANK_CYCLES(0), .LZ_SUPPRESS(1'b1)) u_nb (
    .clk(clk), .rst(rst), .en(en), .load_valid(load_valid), .load_bcd(load_bcd),
    .load_ready(rdy_c), .seg(seg_c), .digit_sel(sel_c), .frame_done(fd_c)
  );

  always_comb begin
    obs_rdy = rdy_a; obs_seg = seg_a; obs_sel = sel_a; obs_fd = fd_a;
    case (ds)
      1: begin obs_rdy = rdy_b; obs_seg = seg_b; obs_sel = sel_b; obs_fd = fd_b; end
      2: begin obs_rdy = rdy_c; obs_seg = seg_c; obs_sel = sel_c; obs_fd = fd_c; end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] exp_seg(input logic [11:0] v, input int slot, input bit lz);
    logic [3:0] n;
    n = v[slot*4 +: 4];
    if (lz && slot == 2 && v[11:8] == 4'd0) return 7'd0;
    if (lz && slot == 1 && v[11:4] == 8'd0) return 7'd0;
    case (n)
      4'd0: return 7'b1111110;
      4'd1: return 7'b0110000;
      4'd2: return 7'b1101101;
      4'd3: return 7'b1111001;
      4'd4: return 7'b0110011;
      4'd5: return 7'b1011011;
      4'd6: return 7'b1011111;
      4'd7: return 7'b1110000;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1111011;
      default: return 7'b0000001;
    endcase
  endfunction

  // Walks one frame cycle by cycle; optional offers, drop of load_valid and en abort.
  task automatic run_frame(input int d, input logic [11:0] val, input int b, input bit lz,
                           input bit fd, input int off_at, input logic [11:0] off_val,
                           input int off2_at, input logic [11:0] off2_val,
                           input int drop_at, input int abort_at);
    int per, slot, off;
    logic [2:0] esel;
    logic [6:0] eseg;
    ds  = d;
    per = b + 4;
    for (int p = 0; p < 3 * per; p++) begin
      tick();
      slot = p / per;
      off  = p % per;
      if (off >= b) begin
        esel = 3'b001 << slot;
        eseg = exp_seg(val, slot, lz);
      end else begin
        esel = 3'b000;
        eseg = 7'd0;
      end
      chk($sformatf("sel d%0d v%03h p%0d", d, val, p), obs_sel, esel);
      chk($sformatf("seg d%0d v%03h p%0d", d, val, p), obs_seg, eseg);
      chk($sformatf("frame_done d%0d v%03h p%0d", d, val, p), obs_fd, (p == 0) && fd);
      if (p == 0 && fd) chk($sformatf("ready at boundary d%0d", d), obs_rdy, 1);
      if (off_at >= 0 && p == off_at + 1) chk($sformatf("ready after accept d%0d", d), obs_rdy, 0);
      if (p == drop_at) begin
        chk($sformatf("ready before drop d%0d", d), obs_rdy, 0);
        load_valid = 1'b0;
      end
      if (p == off_at) begin
        load_valid = 1'b1;
        load_bcd   = off_val;
      end
      if (p == off2_at) begin
        load_valid = 1'b1;
        load_bcd   = off2_val;
      end
      if (p == abort_at) begin
        en = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load_valid = 1'b0; load_bcd = 12'h000; ds = 0;
    tick();
    tick();
    chk("reset seg", obs_seg, 0);
    chk("reset digit_sel", obs_sel, 0);
    chk("reset frame_done", obs_fd, 0);
    chk("reset load_ready", obs_rdy, 0);
    rst = 1'b0;
    tick();
    chk("idle load_ready", obs_rdy, 1);
    chk("idle digit_sel", obs_sel, 0);
    en = 1'b1;

    run_frame(0, 12'h000, 2, 1'b1, 1'b0, -1, 12'h000, -1, 12'h000, -1, -1);
    run_frame(0, 12'h000, 2, 1'b1, 1'b1,  3, 12'h305, -1, 12'h000,  4, -1);
    run_frame(0, 12'h305, 2, 1'b1, 1'b1,  2, 12'h012,  3, 12'h999, -1, -1);
    run_frame(0, 12'h012, 2, 1'b1, 1'b1, -1, 12'h000, -1, 12'h000,  1, -1);
    run_frame(0, 12'h999, 2, 1'b1, 1'b1, -1, 12'h000, -1, 12'h000, -1,  9);

    tick();
    chk("abort seg", obs_seg, 0);
    chk("abort digit_sel", obs_sel, 0);
    chk("abort frame_done", obs_fd, 0);
    load_valid = 1'b1;
    load_bcd   = 12'h456;
    tick();
    chk("idle accept ready", obs_rdy, 0);
    load_valid = 1'b0;
    tick();
    chk("idle frame_done", obs_fd, 0);
    chk("idle dark", obs_sel, 0);
    en = 1'b1;
    run_frame(0, 12'h456, 2, 1'b1, 1'b0, -1, 12'h000, -1, 12'h000, -1, -1);

    rst = 1'b1; en = 1'b0;
    tick();
    rst = 1'b0;
    load_valid = 1'b1;
    load_bcd   = 12'h0A7;
    tick();
    load_valid = 1'b0;
    en = 1'b1;
    run_frame(1, 12'h0A7, 2, 1'b0, 1'b0, -1, 12'h000, -1, 12'h000, -1, -1);

    rst = 1'b1; en = 1'b0;
    tick();
    rst = 1'b0;
    load_valid = 1'b1;
    load_bcd   = 12'h0A7;
    tick();
    load_valid = 1'b0;
    en = 1'b1;
    run_frame(2, 12'h0A7, 0, 1'b1, 1'b0, -1, 12'h000, -1, 12'h000, -1, -1);
    run_frame(2, 12'h0A7, 0, 1'b1, 1'b1, -1, 12'h000, -1, 12'h000, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/d7s_scan_ctrl.md
Name: d7s_scan_ctrl

Overview:
Scan scheduler for the 3-digit multiplexed seven-segment display. It time-shares the single segment bus between three digit-drive transistors. It accepts a 3-digit BCD word through a valid/ready handshake and double-buffers it so updates land only on frame boundaries. It inserts a blanking gap between digits to suppress ghosting, and it drives the segment pins and transistor selects in the top-level wrapper.

Parameters:
DWELL_CYCLES, 1000, clocks each digit is lit (>=1)
BLANK_CYCLES, 16, clocks of all-off gap before each digit (0 = no gap state)
LZ_SUPPRESS, 1, 1 = blank leading zeros on digits 2 and 1

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
en  input  1  scan enable; 0 = display dark
load_valid  input  1  new value offered
load_bcd  input  12  {d2,d1,d0} BCD nibbles, d0 = least significant
load_ready  output  1  value accepted when load_valid & load_ready
seg  output  7  segments {a,b,c,d,e,f,g}, seg[6]=a, active-high
digit_sel  output  3  one-hot transistor enable, bit i = digit i, active-high
frame_done  output  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset while rst=1 at a clock edge: state IDLE; seg=0; digit_sel=0; frame_done=0; display reg=0x000; pending empty; digit index=0; counters=0. load_ready=0 while rst is high.
- Registers: display reg (12b, the value being shown) and pending reg (12b plus valid flag).
- load_ready = ~pending_valid & ~rst. Accept on load_valid & load_ready; pending_valid sets next cycle. Accept and commit never coincide because ready is low while pending is full.
- Commit (pending -> display, pending_valid cleared): at a frame boundary, or on the first cycle of IDLE->scan start. A value accepted in the same cycle as a boundary commits at the next boundary, one frame later.
- FSM states: IDLE, BLANK, SHOW.
  - IDLE: outputs 0. When en=1, go to BLANK with digit 0, or SHOW digit 0 if BLANK_CYCLES=0.
  - BLANK: seg=0, digit_sel=0, for BLANK_CYCLES clocks, then SHOW at the same index.
  - SHOW i: digit_sel=1<<i, seg=decode(nibble i), for DWELL_CYCLES clocks.
    - After SHOW i, i<2: BLANK at i+1.
    - After SHOW 2: wrap to index 0. This is the frame boundary: commit occurs and frame_done=1 during the first cycle of the new frame.
- Frame length = 3*(BLANK_CYCLES+DWELL_CYCLES) clocks.
- seg and digit_sel are registered and change on the same edge as the state change. No clock ever has a non-zero digit_sel together with the previous digit's segments.
- Decode, nibble -> seg: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011. Codes 10-15 -> 0000001 (dash).
- Leading-zero suppression (LZ_SUPPRESS=1):
  - d2==0 -> digit 2 seg=0.
  - d1==0 and d2==0 -> digit 1 seg=0.
  - Digit 0 is never suppressed.
  - digit_sel still asserts for suppressed digits, keeping duty cycle uniform.
- en drop mid-frame: next edge goes to IDLE, outputs 0, index and counters cleared, display reg kept. Handshake stays live while in IDLE. On en re-rise, commit any pending value, then start at digit 0. No frame_done is generated for the aborted frame.
- Counters: ceil(log2(max(DWELL,BLANK)+1)) bits; wrap only through the FSM.

Test Plan (DWELL_CYCLES=4, BLANK_CYCLES=2 unless stated):
- Reset, en=1, no load -> repeating sequence per digit: 2 clocks (digit_sel=000, seg=0) then 4 clocks (digit_sel=001/010/100). seg=1111110 on digit 0 and seg=0 on digits 1 and 2 (suppressed). frame_done pulses every 18 clocks.
- Load 0x305 mid-frame -> load_ready falls the next cycle. Current frame keeps its old value. From the next frame, digit 0 shows 1011011, digit 1 shows 1111110 (not suppressed because d2≠0), digit 2 shows 1111001. load_ready returns high with frame_done.
- Load 0x0A7 with LZ_SUPPRESS=0 -> digit 1 shows 0000001 and digit 2 shows 1111110.
- Second load_valid held while pending is full -> not accepted until the commit. The first value is shown for one full frame before the second.
- en dropped during SHOW digit 1 -> next clock seg=0 and digit_sel=0 with no frame_done. On en re-rise the scan restarts at the BLANK of digit 0.
- BLANK_CYCLES=0 -> digit_sel steps directly 001->010->100 every 4 clocks; frame_done every 12 clocks.
